// File: rtl/io_bus_pkg.sv
// Shared definitions for the 16-bit memory-mapped IO bus: control bit
// positions, IO region decode field and the initiator FSM state encoding.
package io_bus_pkg;

    // Bit positions inside control_out_io
    localparam int IO_CTRL_BYTE  = 0;
    localparam int IO_CTRL_WRITE = 1;

    // IO region select field of the byte address
    localparam int         IO_REGION_MSB = 31;
    localparam int         IO_REGION_LSB = 26;
    localparam logic [5:0] IO_REGION_VGA = 6'd1;

    // Width of the read latency counter (latency 1..7)
    localparam int IO_LAT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        RESP
    } io_state_e;

    // Extract the IO region number from a byte address
    function automatic logic [5:0] io_region(input logic [31:0] addr);
        return addr[IO_REGION_MSB:IO_REGION_LSB];
    endfunction

endpackage

// File: rtl/io_bus_master.sv
// Initiator side of the 16-bit IO bus. Takes single read/write requests over
// a valid/ready handshake, drives registered address/data/control toward the
// responder and captures read data after a fixed pipelined latency.
// Optional build macro IO_BUS_MASTER_DWORD_EN enables 32-bit accesses split
// into two 16-bit transfers (low half at addr, high half at addr+2).
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic        main_clk,
    input  logic        main_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_dword,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [31:0] address_out_io,
    output logic [15:0] data_in_io,
    output logic [1:0]  control_out_io,
    input  logic [15:0] data_out_io
);

    localparam logic [IO_LAT_W-1:0] LAT_LOAD = IO_LAT_W'(READ_LATENCY);

    io_state_e             state_reg, state_next;
    logic [31:0]           addr_reg, addr_next;
    logic [15:0]           data_reg, data_next;
    logic [1:0]            ctrl_reg, ctrl_next;
    logic [IO_LAT_W-1:0]   cnt_reg, cnt_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [31:0]           rdata_reg, rdata_next;
    logic                  dword_reg, dword_next;       // current access is 32-bit
    logic                  hi_pending_reg, hi_pending_next; // high half still to transfer
    logic [15:0]           hi_data_reg, hi_data_next;   // high half of dword write data

    logic                  dword_req;
    logic                  eff_byte;
    logic [31:0]           eff_addr;

`ifdef IO_BUS_MASTER_DWORD_EN
    assign dword_req = req_dword;
`else
    // Without dword support the request flag has no effect
    logic unused_dword;
    assign dword_req    = 1'b0;
    assign unused_dword = req_dword;
`endif

    // A dword access is always a pair of aligned 16-bit word transfers
    assign eff_byte = req_byte & ~dword_req;
    assign eff_addr = dword_req ? {req_addr[31:1], 1'b0} : req_addr;

    // State, bus and response registers; reset drops the strobe at once
    always_ff @(posedge main_clk or posedge main_reset) begin
        if (main_reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            data_reg       <= '0;
            ctrl_reg       <= '0;
            cnt_reg        <= '0;
            rsp_valid_reg  <= 1'b0;
            rdata_reg      <= '0;
            dword_reg      <= 1'b0;
            hi_pending_reg <= 1'b0;
            hi_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            ctrl_reg       <= ctrl_next;
            cnt_reg        <= cnt_next;
            rsp_valid_reg  <= rsp_valid_next;
            rdata_reg      <= rdata_next;
            dword_reg      <= dword_next;
            hi_pending_reg <= hi_pending_next;
            hi_data_reg    <= hi_data_next;
        end
    end

    // Next-state, bus values and handshake decode
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        ctrl_next       = ctrl_reg;
        cnt_next        = cnt_reg;
        rsp_valid_next  = 1'b0;
        rdata_next      = rdata_reg;
        dword_next      = dword_reg;
        hi_pending_next = hi_pending_reg;
        hi_data_next    = hi_data_reg;
        req_ready       = 1'b0;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                ctrl_next = '0;
            end
            WRITE: begin
                if (hi_pending_reg) begin
                    // Second strobe of a dword write: high half at addr+2
                    addr_next                = addr_reg + 32'd2;
                    data_next                = hi_data_reg;
                    ctrl_next                = '0;
                    ctrl_next[IO_CTRL_WRITE] = 1'b1;
                    hi_pending_next          = 1'b0;
                end else begin
                    req_ready  = 1'b1;
                    ctrl_next  = '0;
                    state_next = IDLE;
                end
            end
            READ_WAIT: begin
                if (cnt_reg == '0) begin
                    if (hi_pending_reg) begin
                        // Low half captured; rerun the read for the high half
                        rdata_next      = {16'h0000, data_out_io};
                        addr_next       = addr_reg + 32'd2;
                        ctrl_next       = '0;
                        cnt_next        = LAT_LOAD;
                        hi_pending_next = 1'b0;
                    end else begin
                        if (dword_reg) begin
                            rdata_next = {data_out_io, rdata_reg[15:0]};
                        end else begin
                            rdata_next = {16'h0000, data_out_io};
                        end
                        rsp_valid_next = 1'b1;
                        ctrl_next      = '0;
                        state_next     = RESP;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                ctrl_next  = '0;
            end
        endcase

        // Acceptance starts the new bus cycle, overriding the idle values above
        if (req_valid && req_ready) begin
            addr_next       = eff_addr;
            cnt_next        = LAT_LOAD;
            dword_next      = dword_req;
            hi_pending_next = dword_req;
            hi_data_next    = req_wdata[31:16];
            ctrl_next       = '0;
            ctrl_next[IO_CTRL_BYTE] = eff_byte;
            if (req_write) begin
                state_next               = WRITE;
                ctrl_next[IO_CTRL_WRITE] = 1'b1;
                data_next = eff_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata[15:0];
            end else begin
                state_next = READ_WAIT;
            end
        end
    end

    assign address_out_io = addr_reg;
    assign data_in_io     = data_reg;
    assign control_out_io = ctrl_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_rdata      = rdata_reg;

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master. A per-cycle expectation table is
// filled from each accepted request using the bus timing rules, and a
// negedge monitor compares every cycle's outputs against it. A pipelined
// responder model returns a fixed function of the address.
module tb_io_bus_master;

    localparam int L    = 2;
    localparam int NCYC = 4096;
`ifdef IO_BUS_MASTER_DWORD_EN
    localparam bit DW_EN = 1'b1;
`else
    localparam bit DW_EN = 1'b0;
`endif

    logic        main_clk;
    logic        main_reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_dword;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] address_out_io;
    logic [15:0] data_in_io;
    logic [1:0]  control_out_io;
    logic [15:0] data_out_io;

    io_bus_master #(.READ_LATENCY(L)) dut (
        .main_clk       (main_clk),
        .main_reset     (main_reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_byte       (req_byte),
        .req_dword      (req_dword),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .address_out_io (address_out_io),
        .data_in_io     (data_in_io),
        .control_out_io (control_out_io),
        .data_out_io    (data_out_io)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    int n_checks;
    int n_errors;
    int n_txn;
    int cyc;
    bit mon_en;
    logic [31:0] last_ea;

    // Expected behaviour per clock period (period p follows rising edge p)
    logic [1:0]  exp_ctrl  [NCYC];
    bit          exp_ready [NCYC];
    bit          exp_rsp   [NCYC];
    bit          exp_achk  [NCYC];
    logic [31:0] exp_addr  [NCYC];
    logic [31:0] exp_rdata [NCYC];
    logic [15:0] exp_data  [NCYC];

    // Responder contents: a few fixed words, otherwise a scrambled address
    function automatic logic [15:0] resp_word(input logic [31:0] a);
        case (a)
            32'h04000020: return 16'h1234;
            32'hFFFFFFFE: return 16'h1111;
            32'h00000000: return 16'h2222;
            default:      return 16'(a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h5A0F;
        endcase
    endfunction

    // Responder with L register stages between address and read data
    logic [15:0] pipe [L];
    always @(posedge main_clk) begin
        pipe[0] <= resp_word(address_out_io);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign data_out_io = pipe[L-1];

    always @(posedge main_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic clear_model(input int from);
        for (int p = from; p < NCYC; p++) begin
            exp_ctrl[p]  = 2'b00;
            exp_ready[p] = 1'b1;
            exp_rsp[p]   = 1'b0;
            exp_achk[p]  = 1'b0;
            exp_addr[p]  = '0;
            exp_data[p]  = '0;
            exp_rdata[p] = '0;
        end
    endtask

    task automatic set_bus(input int p, input logic [1:0] c, input logic [31:0] a,
                           input logic [15:0] d, input bit rdy);
        if (p < NCYC) begin
            exp_ctrl[p]  = c;
            exp_addr[p]  = a;
            exp_data[p]  = d;
            exp_achk[p]  = 1'b1;
            exp_ready[p] = rdy;
        end
    endtask

    task automatic set_rsp(input int p, input logic [31:0] v);
        if (p < NCYC) begin
            exp_rsp[p]   = 1'b1;
            exp_rdata[p] = v;
            exp_ready[p] = 1'b0;
        end
    endtask

    // Expected bus activity for a request accepted on rising edge e
    task automatic model_accept(input int e, input logic w, input logic b, input logic d,
                                input logic [31:0] a, input logic [31:0] wd);
        logic        dw;
        logic        bb;
        logic [31:0] a0;
        logic [7:0]  lo8;
        dw  = d & DW_EN;
        bb  = b & ~dw;
        a0  = dw ? {a[31:1], 1'b0} : a;
        lo8 = wd[7:0];
        if (w) begin
            if (dw) begin
                set_bus(e,     2'b10, a0,         wd[15:0],  1'b0);
                set_bus(e + 1, 2'b10, a0 + 32'd2, wd[31:16], 1'b1);
            end else begin
                set_bus(e, {1'b1, bb}, a0, bb ? {lo8, lo8} : wd[15:0], 1'b1);
            end
        end else begin
            for (int p = e; p <= e + L; p++) set_bus(p, {1'b0, bb}, a0, 16'h0000, 1'b0);
            if (dw) begin
                for (int p = e + L + 1; p <= e + 2*L + 1; p++)
                    set_bus(p, 2'b00, a0 + 32'd2, 16'h0000, 1'b0);
                set_rsp(e + 2*L + 2, {resp_word(a0 + 32'd2), resp_word(a0)});
            end else begin
                set_rsp(e + L + 1, {16'h0000, resp_word(a0)});
            end
        end
    endtask

    // Present one request at a falling edge and hold it until the model accepts it
    task automatic issue(input logic w, input logic b, input logic d,
                         input logic [31:0] a, input logic [31:0] wd);
        int waits;
        waits     = 0;
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_dword = d;
        req_addr  = a;
        req_wdata = wd;
        while (!exp_ready[cyc] && waits < 64) begin
            @(negedge main_clk);
            waits++;
        end
        if (waits >= 64) begin
            check_eq("stall_bound", 32'(waits), 32'd0);
        end else begin
            model_accept(cyc + 1, w, b, d, a, wd);
            n_txn++;
            $display("txn %0d: wr=%0b byte=%0b dword=%0b addr=%h wdata=%h edge=%0d",
                     n_txn, w, b, d, a, wd, cyc + 1);
        end
        @(negedge main_clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge main_clk);
    endtask

    // Per-cycle comparison of all outputs against the expectation table
    always @(negedge main_clk) begin
        if (mon_en && cyc < NCYC) begin
            check_eq("ctrl",      32'(control_out_io), 32'(exp_ctrl[cyc]));
            check_eq("ready",     32'(req_ready),      32'(exp_ready[cyc]));
            check_eq("rsp_valid", 32'(rsp_valid),      32'(exp_rsp[cyc]));
            if (exp_achk[cyc]) last_ea = exp_addr[cyc];
            check_eq("addr", address_out_io, last_ea);
            if (exp_ctrl[cyc][1]) check_eq("wdata", 32'(data_in_io), 32'(exp_data[cyc]));
            if (exp_rsp[cyc]) check_eq("rdata", rsp_rdata, exp_rdata[cyc]);
        end
    end

    task automatic check_reset_outputs(input string phase);
        check_eq({phase, "_addr"},  address_out_io,       32'h0);
        check_eq({phase, "_data"},  32'(data_in_io),      32'h0);
        check_eq({phase, "_ctrl"},  32'(control_out_io),  32'h0);
        check_eq({phase, "_rsp"},   32'(rsp_valid),       32'h0);
        check_eq({phase, "_rdata"}, rsp_rdata,            32'h0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        n_txn      = 0;
        cyc        = 0;
        mon_en     = 1'b0;
        last_ea    = '0;
        main_reset = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_byte   = 1'b0;
        req_dword  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        clear_model(0);

        repeat (3) @(negedge main_clk);
        check_reset_outputs("rst");
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        main_reset = 1'b0;
        mon_en     = 1'b1;
        idle(2);

        // Word write, byte write, word read
        issue(1'b1, 1'b0, 1'b0, 32'h04000010, 32'h00000ABC);
        issue(1'b1, 1'b1, 1'b0, 32'h04000003, 32'h0000005A);
        idle(2);
        issue(1'b0, 1'b0, 1'b0, 32'h04000020, 32'h0);
        // Three back-to-back writes then a read during the third strobe
        issue(1'b1, 1'b0, 1'b0, 32'h04000100, 32'h00001111);
        issue(1'b1, 1'b1, 1'b0, 32'h04000101, 32'h000000C3);
        issue(1'b1, 1'b0, 1'b0, 32'h04000102, 32'h0000BEEF);
        issue(1'b0, 1'b0, 1'b0, 32'h04000020, 32'h0);
        idle(1);

        // Reset asserted while a read is waiting for data
        issue(1'b0, 1'b0, 1'b0, 32'h04000044, 32'h0);
        @(posedge main_clk);
        #2;
        main_reset = 1'b1;
        mon_en     = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_model(cyc);
        last_ea = '0;
        idle(2);
        main_reset = 1'b0;
        check_eq("midrst_ready", 32'(req_ready), 32'd1);
        mon_en = 1'b1;
        idle(L + 4);

`ifdef IO_BUS_MASTER_DWORD_EN
        // Dword read wrapping across the top of the address space, and a dword write
        issue(1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h0);
        issue(1'b1, 1'b1, 1'b1, 32'h04000011, 32'hCAFE5A5A);
        issue(1'b1, 1'b0, 1'b0, 32'h04000020, 32'h00007777);
`endif

        // Randomised mix of reads and writes with occasional idle gaps
        for (int i = 0; i < 120; i++) begin
            logic        w;
            logic        b;
            logic        d;
            logic [31:0] a;
            logic [31:0] wd;
            w  = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 3) == 0);
            a  = {6'($urandom_range(0, 3)), 26'($urandom)};
            wd = $urandom;
            issue(w, b, d, a, wd);
            idle($urandom_range(0, 2));
        end

        idle(2*L + 8);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
